// File: rtl/boot_loader_pkg.sv
// Shared types and sizing constants for the byte-stream image loader.
package boot_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned LEN_W          = 8 * LEN_BYTES;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_e;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs accepted bytes into a little-endian word; lane chosen by a 2-bit index.
module word_assembler
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_i,
  input  logic              byte_en_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_c
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_en_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + IDX_W'(1);
    end
  end

  // High in the same cycle the final lane is being accepted.
  assign word_full_c = byte_en_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction memory and
// holds the core in reset until the image verifies.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_waddress,
  output logic [31:0] mem_datain,
  output logic        mem_wr,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_wr_q, mem_wr_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept_c;
  logic              asm_full_c;
  logic [LEN_W-1:0]  len_rx_c;
  logic [WORD_W-1:0] asm_word;

  assign accept_c = rx_valid && rx_ready_q;
  assign len_rx_c = {rx_data, len_q[7:0]};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_i     (rx_data),
    .byte_en_i  (accept_c && (state_q == DATA)),
    .clear_i    (state_q == WRITE),
    .word_o     (asm_word),
    .word_full_c(asm_full_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LEN0;
      len_q       <= '0;
      xor_q       <= '0;
      addr_q      <= BASE_ADDR;
      words_q     <= '0;
      rx_ready_q  <= 1'b1;
      mem_wr_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      xor_q       <= xor_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      rx_ready_q  <= rx_ready_d;
      mem_wr_q    <= mem_wr_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    words_d = words_q;

    // Checksum covers length and data bytes, never the checksum byte itself.
    if (accept_c && (state_q inside {LEN0, LEN1, DATA})) begin
      xor_d = xor_q ^ rx_data;
    end

    case (state_q)
      LEN0: begin
        if (accept_c) begin
          len_d[7:0] = rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept_c) begin
          len_d = len_rx_c;
          if (len_rx_c > LEN_W'(MAX_WORDS)) begin
            state_d = ERR;
          end else if (len_rx_c == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_full_c) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        addr_d  = addr_q + 32'(BYTES_PER_WORD);
        state_d = ((words_q + 16'd1) == len_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept_c) begin
          state_d = (rx_data == xor_q) ? RUN : ERR;
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    // Outputs are registered decodes of the state being entered.
    rx_ready_d  = state_d inside {LEN0, LEN1, DATA, CSUM};
    mem_wr_d    = (state_d == WRITE);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERR);
    cpu_reset_d = (state_d != RUN);
  end

  assign rx_ready     = rx_ready_q;
  assign mem_waddress = addr_q;
  assign mem_datain   = asm_word;
  assign mem_wr       = mem_wr_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
